// File: rtl/calc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : calc_sequencer
// Description : Calculator operation sequencer. Collects two operands and an
//               operator from enter-button presses, runs the shared ALU with
//               a start/done handshake and a timeout, then holds the result
//               or an error for the display. A shown result can be chained
//               in as the next left operand.
//               Optional enter-button debounce: define CALC_SEQ_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_sequencer #(
    parameter int WIDTH           = 8,
    parameter int TIMEOUT         = 15,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] key_data,
    input  logic [1:0]       key_op,
    input  logic             key_enter,
    input  logic             key_clear,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_err,
    output logic [WIDTH-1:0] disp_value,
    output logic             disp_err,
    output logic [2:0]       phase
);

    // State encoding doubles as the phase shown on the status LEDs.
    localparam logic [2:0] c_ST_GET_A = 3'd0;
    localparam logic [2:0] c_ST_GET_B = 3'd1;
    localparam logic [2:0] c_ST_EXEC  = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_SHOW  = 3'd4;
    localparam logic [2:0] c_ST_ERR   = 3'd5;

    // Timeout counter only needs to reach TIMEOUT-1.
    localparam int               c_TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_lvl_prev;
    logic              w_level;
    logic              w_press;

    logic [2:0]        r_state,      w_state;
    logic [WIDTH-1:0]  r_alu_a,      w_alu_a;
    logic [WIDTH-1:0]  r_alu_b,      w_alu_b;
    logic [1:0]        r_alu_op,     w_alu_op;
    logic [WIDTH-1:0]  r_disp_value, w_disp_value;
    logic              r_disp_err,   w_disp_err;
    logic [c_TO_W-1:0] r_to_cnt,     w_to_cnt;

    // Two-flop synchronizer for the asynchronous enter button; runs even when disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= key_enter;
            r_sync2 <= r_sync1;
        end
    end

`ifdef CALC_SEQ_DEBOUNCE_EN
    localparam int               c_DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);

    logic              r_filt;
    logic [c_DB_W-1:0] r_db_cnt;

    // Filtered level flips only after the synchronized level differs for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt   <= 1'b0;
            r_db_cnt <= '0;
        end else if (r_sync2 == r_filt) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == c_DB_LAST) begin
            r_filt   <= r_sync2;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + c_DB_W'(1);
        end
    end

    assign w_level = r_filt;
`else
    // No filter: the synchronized level feeds the edge detector directly.
    // Both arms are identical; the condition only keeps DEBOUNCE_CYCLES referenced.
    if (DEBOUNCE_CYCLES >= 0) begin : g_no_filter
        assign w_level = r_sync2;
    end else begin : g_no_filter_alt
        assign w_level = r_sync2;
    end
`endif

    // Edge register; keeps tracking while disabled so presses then are consumed, not queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lvl_prev <= 1'b0;
        end else begin
            r_lvl_prev <= w_level;
        end
    end

    assign w_press = w_level & ~r_lvl_prev;

    // State and datapath registers; everything holds while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_GET_A;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= 2'b00;
            r_disp_value <= '0;
            r_disp_err   <= 1'b0;
            r_to_cnt     <= '0;
        end else if (ena) begin
            r_state      <= w_state;
            r_alu_a      <= w_alu_a;
            r_alu_b      <= w_alu_b;
            r_alu_op     <= w_alu_op;
            r_disp_value <= w_disp_value;
            r_disp_err   <= w_disp_err;
            r_to_cnt     <= w_to_cnt;
        end
    end

    // Next-state and datapath updates; clear outranks presses and ALU completion.
    always_comb begin
        w_state      = r_state;
        w_alu_a      = r_alu_a;
        w_alu_b      = r_alu_b;
        w_alu_op     = r_alu_op;
        w_disp_value = r_disp_value;
        w_disp_err   = r_disp_err;
        w_to_cnt     = r_to_cnt;
        if (key_clear) begin
            w_state      = c_ST_GET_A;
            w_alu_a      = '0;
            w_alu_b      = '0;
            w_alu_op     = 2'b00;
            w_disp_value = '0;
            w_disp_err   = 1'b0;
            w_to_cnt     = '0;
        end else begin
            case (r_state)
                c_ST_GET_A: begin
                    if (w_press) begin
                        w_alu_a      = key_data;
                        w_disp_value = key_data;
                        w_state      = c_ST_GET_B;
                    end
                end
                c_ST_GET_B: begin
                    if (w_press) begin
                        w_alu_b      = key_data;
                        w_alu_op     = key_op;
                        w_disp_value = key_data;
                        w_state      = c_ST_EXEC;
                    end
                end
                c_ST_EXEC: begin
                    w_to_cnt = '0;
                    w_state  = c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    // A done in the last counted cycle still beats the timeout.
                    if (alu_done) begin
                        if (alu_err) begin
                            w_disp_err = 1'b1;
                            w_state    = c_ST_ERR;
                        end else begin
                            w_disp_value = alu_result;
                            w_state      = c_ST_SHOW;
                        end
                    end else if (r_to_cnt == c_TO_LAST) begin
                        w_disp_err = 1'b1;
                        w_state    = c_ST_ERR;
                    end else begin
                        w_to_cnt = r_to_cnt + c_TO_W'(1);
                    end
                end
                c_ST_SHOW: begin
                    if (w_press) begin
                        w_alu_a = r_disp_value;
                        w_state = c_ST_GET_B;
                    end
                end
                c_ST_ERR: begin
                    if (w_press) begin
                        w_disp_err   = 1'b0;
                        w_disp_value = '0;
                        w_state      = c_ST_GET_A;
                    end
                end
                default: begin
                    w_state = c_ST_GET_A;
                end
            endcase
        end
    end

    assign alu_start  = ena & (r_state == c_ST_EXEC);
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign disp_value = r_disp_value;
    assign disp_err   = r_disp_err;
    assign phase      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_calc_sequencer
// Description : Scoreboard bench for calc_sequencer. Stimulus tasks push the
//               expected ALU start operands and the expected outcome; a
//               monitor pops and compares whenever the DUT starts the ALU or
//               leaves WAIT. A small ALU model answers with bench-computed
//               results after a chosen latency (or never).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_sequencer;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 15;
    localparam int DB      = 4;
    localparam int NEVER   = 99;
    localparam int HOLD    = DB + 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic [WIDTH-1:0] key_data;
    logic [1:0]       key_op;
    logic             key_enter;
    logic             key_clear;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_op;
    logic             alu_start;
    logic             alu_done;
    logic [WIDTH-1:0] alu_result;
    logic             alu_err;
    logic [WIDTH-1:0] disp_value;
    logic             disp_err;
    logic [2:0]       phase;

    calc_sequencer #(
        .WIDTH(WIDTH),
        .TIMEOUT(TIMEOUT),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .key_data(key_data),
        .key_op(key_op),
        .key_enter(key_enter),
        .key_clear(key_clear),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_op(alu_op),
        .alu_start(alu_start),
        .alu_done(alu_done),
        .alu_result(alu_result),
        .alu_err(alu_err),
        .disp_value(disp_value),
        .disp_err(disp_err),
        .phase(phase)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] a; logic [7:0] b; logic [1:0] op; } start_t;
    typedef struct { logic [7:0] val; logic err; logic [2:0] ph; int k; } res_t;
    typedef struct { int lat; logic [7:0] res; logic err; } cmd_t;

    start_t exp_start[$];
    res_t   exp_res[$];
    cmd_t   alu_cmd[$];

    int checks = 0;
    int errors = 0;

    // Reference model: what the calculator should hold, at the level of the user's view.
    logic [7:0] m_a    = 8'd0;
    logic [7:0] m_disp = 8'd0;
    int         m_stage = 0;   // 0 need A, 1 need B, 2 showing, 3 error

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic press(input logic [7:0] d, input logic [1:0] op, input int hold, input int gap);
        @(posedge clk); #1;
        key_data  = d;
        key_op    = op;
        key_enter = 1'b1;
        repeat (hold) @(posedge clk);
        #1 key_enter = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic wait_outcome();
        int n = 0;
        @(negedge clk);
        while (!(phase == 3'd4 || phase == 3'd5) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("outcome_reached", 32'(phase == 3'd4 || phase == 3'd5), 1);
    endtask

    task automatic enter_a(input logic [7:0] v);
        press(v, 2'($urandom_range(0, 3)), HOLD, DB + 6);
        m_a     = v;
        m_disp  = v;
        m_stage = 1;
    endtask

    task automatic enter_b(input logic [7:0] v, input logic [1:0] op, input int lat);
        logic [7:0] r;
        logic       aerr;
        start_t     s;
        cmd_t       c;
        res_t       e;
        case (op)
            2'd0:    r = m_a + v;
            2'd1:    r = m_a - v;
            2'd2:    r = m_a * v;
            default: r = (v == 8'd0) ? 8'd0 : m_a / v;
        endcase
        aerr = (op == 2'd3) && (v == 8'd0);
        s.a = m_a; s.b = v; s.op = op;
        c.lat = lat; c.res = r; c.err = aerr;
        e.k = (lat <= TIMEOUT) ? lat : TIMEOUT;
        if (lat <= TIMEOUT && !aerr) begin
            e.val = r; e.err = 1'b0; e.ph = 3'd4;
        end else begin
            e.val = v; e.err = 1'b1; e.ph = 3'd5;
        end
        exp_start.push_back(s);
        alu_cmd.push_back(c);
        exp_res.push_back(e);
        m_disp  = e.val;
        m_stage = e.err ? 3 : 2;
        press(v, op, HOLD, DB + 6);
        wait_outcome();
    endtask

    task automatic press_show();
        press(8'($urandom), 2'($urandom_range(0, 3)), HOLD, DB + 6);
        m_a     = m_disp;
        m_stage = 1;
    endtask

    task automatic press_err();
        press(8'($urandom), 2'($urandom_range(0, 3)), HOLD, DB + 6);
        m_disp  = 8'd0;
        m_stage = 0;
        @(negedge clk);
        check("err_exit_phase", 32'(phase), 0);
        check("err_exit_disp", 32'(disp_value), 32'(m_disp));
        check("err_exit_err", 32'(disp_err), 0);
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 key_clear = 1'b1;
        @(posedge clk); #1 key_clear = 1'b0;
        m_a = 8'd0; m_disp = 8'd0; m_stage = 0;
    endtask

    // ALU model: answers each start with the bench-computed result after the chosen latency.
    initial begin
        cmd_t c;
        alu_done   = 1'b0;
        alu_result = '0;
        alu_err    = 1'b0;
        forever begin
            @(negedge clk);
            if (alu_start && rst_n && alu_cmd.size() > 0) begin
                c = alu_cmd.pop_front();
                if (c.lat < NEVER) begin
                    @(posedge clk);
                    repeat (c.lat - 1) @(posedge clk);
                    #1;
                    alu_done   = 1'b1;
                    alu_result = c.res;
                    alu_err    = c.err;
                    @(posedge clk); #1;
                    alu_done   = 1'b0;
                    alu_err    = 1'b0;
                    alu_result = 8'($urandom);
                end
            end
        end
    end

    // Monitor: compares ALU start operands and WAIT outcomes against the queues.
    initial begin
        int         cyc = 0;
        int         start_cyc = 0;
        logic [2:0] pp = 3'd0;
        logic       ps = 1'b0;
        start_t     s;
        res_t       e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pp = phase;
                ps = 1'b0;
                continue;
            end
            if (alu_start) begin
                check("start_single_cycle", 32'(ps), 0);
                if (exp_start.size() == 0) begin
                    check("start_unexpected", 1, 0);
                end else begin
                    s = exp_start.pop_front();
                    check("start_alu_a", 32'(alu_a), 32'(s.a));
                    check("start_alu_b", 32'(alu_b), 32'(s.b));
                    check("start_alu_op", 32'(alu_op), 32'(s.op));
                end
                start_cyc = cyc;
            end
            if (pp == 3'd3 && (phase == 3'd4 || phase == 3'd5)) begin
                if (exp_res.size() == 0) begin
                    check("result_unexpected", 1, 0);
                end else begin
                    e = exp_res.pop_front();
                    check("res_disp_value", 32'(disp_value), 32'(e.val));
                    check("res_disp_err", 32'(disp_err), 32'(e.err));
                    check("res_phase", 32'(phase), 32'(e.ph));
                    check("res_latency", 32'(cyc - start_cyc), 32'(e.k + 1));
                end
            end
            pp = phase;
            ps = alu_start;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        ena       = 1'b1;
        key_data  = '0;
        key_op    = 2'b00;
        key_enter = 1'b0;
        key_clear = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_phase", 32'(phase), 0);
        check("rst_alu_a", 32'(alu_a), 0);
        check("rst_alu_b", 32'(alu_b), 0);
        check("rst_alu_op", 32'(alu_op), 0);
        check("rst_alu_start", 32'(alu_start), 0);
        check("rst_disp_value", 32'(disp_value), 0);
        check("rst_disp_err", 32'(disp_err), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 7 + 5 with a 3-cycle ALU, then chain 12 - 3.
        enter_a(8'd7);
        enter_b(8'd5, 2'd0, 3);
        check("plan_disp_12", 32'(disp_value), 12);
        press_show();
        enter_b(8'd3, 2'd1, 2);
        check("plan_disp_9", 32'(disp_value), 9);

        // Divide by zero reported by the ALU.
        press_show();
        enter_b(8'd0, 2'd3, 4);
        press_err();

        // Timeout with no answer, then an answer in the very last cycle.
        enter_a(8'd20);
        enter_b(8'd4, 2'd2, NEVER);
        press_err();
        enter_a(8'd30);
        enter_b(8'd6, 2'd0, TIMEOUT);
        check("last_cycle_done_wins", 32'(phase), 4);

        // Clear held across a press in GET_B.
        press_show();
        @(posedge clk); #1 key_clear = 1'b1;
        press(8'd77, 2'd3, HOLD, DB + 6);
        @(posedge clk); #1 key_clear = 1'b0;
        m_a = 8'd0; m_disp = 8'd0; m_stage = 0;
        @(negedge clk);
        check("clr_phase", 32'(phase), 0);
        check("clr_alu_a", 32'(alu_a), 0);
        check("clr_alu_b", 32'(alu_b), 0);
        check("clr_alu_op", 32'(alu_op), 0);
        check("clr_disp_value", 32'(disp_value), 0);
        check("clr_disp_err", 32'(disp_err), 0);

        // Asynchronous reset in the middle of WAIT.
        enter_a(8'd9);
        begin
            start_t s;
            cmd_t   c;
            s.a = 8'd9; s.b = 8'd2; s.op = 2'd2;
            c.lat = NEVER; c.res = 8'd0; c.err = 1'b0;
            exp_start.push_back(s);
            alu_cmd.push_back(c);
        end
        press(8'd2, 2'd2, HOLD, 0);
        n = 0;
        @(negedge clk);
        while (phase != 3'd3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_wait_reached", 32'(phase), 3);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("arst_phase", 32'(phase), 0);
        check("arst_alu_a", 32'(alu_a), 0);
        check("arst_alu_b", 32'(alu_b), 0);
        check("arst_alu_op", 32'(alu_op), 0);
        check("arst_disp_value", 32'(disp_value), 0);
        check("arst_disp_err", 32'(disp_err), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        m_a = 8'd0; m_disp = 8'd0; m_stage = 0;
        repeat (DB + 6) @(posedge clk);

        // Two-cycle glitch on the enter button.
        press(8'd55, 2'd0, 2, DB + 8);
        @(negedge clk);
`ifdef CALC_SEQ_DEBOUNCE_EN
        check("glitch_phase", 32'(phase), 0);
`else
        check("glitch_phase", 32'(phase), 1);
`endif
        pulse_clear();
        // Long press: exactly one advance.
        press(8'd42, 2'd0, 10, DB + 8);
        @(negedge clk);
        check("long_press_phase", 32'(phase), 1);
        check("long_press_disp", 32'(disp_value), 42);
        pulse_clear();
        repeat (2) @(posedge clk);

        // Randomized sessions.
        for (int i = 0; i < 40; i++) begin
            case (m_stage)
                0: enter_a(8'($urandom));
                1: begin
                    logic [7:0] b;
                    logic [1:0] op;
                    int         lat;
                    op  = 2'($urandom_range(0, 3));
                    b   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
                    lat = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, TIMEOUT));
                    enter_b(b, op, lat);
                end
                2: press_show();
                default: press_err();
            endcase
        end

        repeat (4) @(posedge clk);
        check("start_queue_drained", 32'(exp_start.size()), 0);
        check("result_queue_drained", 32'(exp_res.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calc_sequencer.md
# calc_sequencer

Operation sequencer for the calculator. It takes operand and operator entries from the user pins, one press of the enter button at a time, and drives the shared ALU with a start/done handshake. It then holds the result or error for the 7-segment display logic, and supports chaining a result as the next left operand. It sits between the `ui_in` decode and the ALU/display path inside the top-level `tt_um_` wrapper.

## Interface
Parameters:
- `WIDTH`, 8: operand and result width.
- `TIMEOUT`, 15: maximum number of cycles in WAIT before an error is forced. Minimum 1.
- `DEBOUNCE_CYCLES`, 4: stability window for the enter button. Used only with the debounce macro.

Ports:
- `clk`, in, 1: clock. All state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `ena`, in, 1: design enable. Low freezes the FSM, all registers and the timeout counter. `alu_start` is forced to 0 while low.
- `key_data`, in, WIDTH: operand value to enter.
- `key_op`, in, 2: operator. 00 add, 01 sub, 10 mul, 11 div.
- `key_enter`, in, 1: raw, asynchronous enter button. A press is a rising edge.
- `key_clear`, in, 1: synchronous clear, level, sampled each cycle.
- `alu_a`, `alu_b`, out, WIDTH: operand registers.
- `alu_op`, out, 2: latched operator.
- `alu_start`, out, 1: one-cycle start pulse.
- `alu_done`, in, 1: ALU completion. Honoured only in WAIT.
- `alu_result`, in, WIDTH: ALU result, valid with `alu_done`.
- `alu_err`, in, 1: ALU error (e.g. divide by zero), valid with `alu_done`.
- `disp_value`, out, WIDTH: value for the display.
- `disp_err`, out, 1: display shows error.
- `phase`, out, 3: current state encoding, for status LEDs.

## Operation
Reset values: state GET_A, `phase`=0, `alu_a`=`alu_b`=0, `alu_op`=0, `alu_start`=0, `disp_value`=0, `disp_err`=0, timeout counter 0.

States and their `phase` encoding:
- GET_A (0): on a press, `alu_a`<=`key_data` and `disp_value`<=`key_data`. Go to GET_B.
- GET_B (1): on a press, `alu_b`<=`key_data`, `alu_op`<=`key_op`, `disp_value`<=`key_data`. Go to EXEC.
- EXEC (2): `alu_start`=1 for exactly this one cycle. Go to WAIT unconditionally and clear the timeout counter.
- WAIT (3), on `alu_done`=1:
  - with `alu_err`=0: `disp_value`<=`alu_result`, go to SHOW.
  - with `alu_err`=1: `disp_err`<=1, go to ERR.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no done, `disp_err`<=1 and go to ERR. A done in that final cycle wins over the timeout.
- SHOW (4): on a press, `alu_a`<=`disp_value` (chaining). Go to GET_B.
- ERR (5): on a press, `disp_err`<=0, `disp_value`<=0. Go to GET_A.

Clear and event rules:
- `key_clear`=1 in any state: next edge restores all reset values. It has priority over a press and over `alu_done`.
- `alu_done` outside WAIT is ignored.
- Presses in EXEC or WAIT are dropped and never queued.
- `alu_a`, `alu_b` and `alu_op` are stable from EXEC until their next latch. The ALU may sample them at any time during WAIT.
- Arithmetic is the ALU's job. This block only moves values and does no width conversion.

## Timing
- Enter path: a two-flop synchronizer plus an edge register. `key_enter` high at edge N produces a one-cycle internal press, and the resulting state and register update occurs at edge N+2.
- Operand entry to start: `alu_start` is high during the cycle after the GET_B update edge.
- Done to display: `alu_done` sampled at edge M updates `disp_value`/`disp_err` and the state at edge M. There is no extra latency.
- Timeout: ERR is entered at the TIMEOUT-th edge after entering WAIT, when done is never seen.
- `rst_n` low acts immediately, in any state including mid-WAIT. Release is synchronous to the next edge; the external reset synchronizer handles this.
- While `ena`=0, the synchronizer keeps sampling but presses are discarded.

## Configuration
- `CALC_SEQ_DEBOUNCE_EN` defined:
  - After synchronization, `key_enter` must hold a new level for DEBOUNCE_CYCLES consecutive cycles before the filtered level changes.
  - A press is a rising edge of the filtered level.
  - Press latency becomes N+2+DEBOUNCE_CYCLES.
- `CALC_SEQ_DEBOUNCE_EN` undefined: no filter, the synchronized edge is used directly, and DEBOUNCE_CYCLES is ignored.

## Test plan
- Reset, then enter 7, then enter 5 with op=00. The ALU model returns 12 after 3 cycles. Expect: `alu_start` high for exactly 1 cycle, `alu_a`=7, `alu_b`=5, `alu_op`=00, `disp_value`=12, `phase`=4.
- From SHOW with 12, press enter, then enter 3 with op=01. Expect `alu_a`=12 and `alu_b`=3. The model returns 9, so `disp_value`=9.
- Divide-by-zero: the ALU answers done with `alu_err`=1. Expect `phase`=5 and `disp_err`=1. The next press gives `phase`=0, `disp_err`=0, `disp_value`=0.
- Timeout with TIMEOUT=15: the ALU never answers. Expect ERR at the 15th edge in WAIT. In a rerun, done arriving in the 15th cycle gives SHOW instead.
- `key_clear` together with a press in GET_B: expect GET_A and all reset values. `rst_n` pulsed low mid-WAIT: outputs go to reset values before the next edge.
- With `CALC_SEQ_DEBOUNCE_EN`: a 2-cycle glitch on `key_enter` gives no state change, and a 10-cycle press gives one advance. Without the macro, the same glitch advances the state.
